// File: rtl/branch_predictor_table.sv
// rtl/branch_predictor_table.sv - PHT of saturating counters, bimodal or gshare indexed, with hit/miss stats
module branch_predictor_table #(
    parameter int PC_W     = 32,
    parameter int PC_LSB   = 2,
    parameter int IDX_W    = 6,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = (1 << CTR_W) - 1,
    parameter int MODE     = 0,
    parameter int HIST_W   = 6,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_req,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_taken,
    input  logic              upd_pred,
    output logic [STAT_W-1:0] stat_total,
    output logic [STAT_W-1:0] stat_miss
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [CTR_W-1:0]  pht [DEPTH];
    logic [HIST_W-1:0] ghr;
    logic [IDX_W-1:0]  pidx;
    logic [IDX_W-1:0]  uidx;
    logic [CTR_W-1:0]  ctr_cur;
    logic [CTR_W-1:0]  ctr_next;
    logic [HIST_W-1:0] ghr_shift;
    logic              unused_pc_bits;

    // Only the index field of each PC feeds the table.
    assign unused_pc_bits = ^{pred_pc, upd_pc};

    // Updates index with the history returned by the caller, never the live GHR.
    assign pidx = pred_pc[PC_LSB +: IDX_W] ^ ((MODE == 1) ? IDX_W'(ghr) : '0);
    assign uidx = upd_pc[PC_LSB +: IDX_W] ^ ((MODE == 1) ? IDX_W'(upd_hist) : '0);

    // Shift form also works for HIST_W == 1.
    assign ghr_shift = (ghr << 1) | HIST_W'(upd_taken);

    always_comb begin
        ctr_cur  = pht[uidx];
        ctr_next = ctr_cur;
        if (upd_taken && (ctr_cur != CTR_MAX)) begin
            ctr_next = ctr_cur + CTR_W'(1);
        end else if (!upd_taken && (ctr_cur != '0)) begin
            ctr_next = ctr_cur - CTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= CTR_W'(CTR_INIT);
            end
            ghr        <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_hist  <= '0;
            stat_total <= '0;
            stat_miss  <= '0;
        end else begin
            pred_valid <= pred_req;
            // Nonblocking writes below give read-before-write on a shared entry.
            if (pred_req) begin
                pred_taken <= pht[pidx][CTR_W-1];
                pred_hist  <= ghr;
            end
            if (upd_valid) begin
                pht[uidx] <= ctr_next;
                if (MODE == 1) begin
                    ghr <= ghr_shift;
                end
                if (stat_total != STAT_MAX) begin
                    stat_total <= stat_total + STAT_W'(1);
                end
                if ((upd_pred != upd_taken) && (stat_miss != STAT_MAX)) begin
                    stat_miss <= stat_miss + STAT_W'(1);
                end
            end
        end
    end
endmodule
